seq_generator: RTL and testbench

//   Serial pattern transmitter: the source end of the single-bit stream consumed by seq_detector.

---
 rtl/seq_generator.sv | 147 ++++++++++++++
 tb/tb_seq_generator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_generator
// Serial MSB-first word transmitter feeding seq_detector. It accepts a word
// over a valid/ready handshake, shifts it out on 'a' and then idles for GAP
// cycles. Optional macro SEQ_GENERATOR_REPEAT_EN adds a 'repeat_en' input.
// Revision : 1.0
// ============================================================================
module seq_generator #(
    parameter int WIDTH = 16,
    parameter int GAP   = 2,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
`ifdef SEQ_GENERATOR_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int               GAP_W      = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [CNT_W-1:0] c_width    = CNT_W'(WIDTH);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
`ifdef SEQ_GENERATOR_REPEAT_EN
    logic [WIDTH-1:0] r_word;
    logic [CNT_W-1:0] r_len;
`endif

    logic [CNT_W-1:0] w_len;
    logic [WIDTH-1:0] w_aligned;

    // The word is left-aligned so the next bit to send is always the MSB.
    always_comb begin
        w_len     = ((load_len == '0) || (load_len > c_width)) ? c_width : load_len;
        w_aligned = load_data << (c_width - w_len);
    end

    assign load_ready = (r_state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            a       <= 1'b0;
            a_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_GENERATOR_REPEAT_EN
            r_word  <= '0;
            r_len   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_state <= S_SEND;
                        r_shift <= w_aligned;
                        r_cnt   <= w_len - 1'b1;
                        a       <= w_aligned[WIDTH-1];
                        a_valid <= 1'b1;
                        busy    <= 1'b1;
`ifdef SEQ_GENERATOR_REPEAT_EN
                        r_word  <= w_aligned;
                        r_len   <= w_len;
`endif
                    end
                end
                S_SEND: begin
                    if (r_cnt == '0) begin
                        a       <= 1'b0;
                        a_valid <= 1'b0;
                        done    <= 1'b1;
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_gap   <= c_gap_last;
                        end else
`ifdef SEQ_GENERATOR_REPEAT_EN
                        if (repeat_en) begin
                            r_state <= S_SEND;
                            r_shift <= r_word;
                            r_cnt   <= r_len - 1'b1;
                            a       <= r_word[WIDTH-1];
                            a_valid <= 1'b1;
                        end else
`endif
                        begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt - 1'b1;
                        a       <= r_shift[WIDTH-2];
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
`ifdef SEQ_GENERATOR_REPEAT_EN
                        if (repeat_en) begin
                            r_state <= S_SEND;
                            r_shift <= r_word;
                            r_cnt   <= r_len - 1'b1;
                            a       <= r_word[WIDTH-1];
                            a_valid <= 1'b1;
                        end else
`endif
                        begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_generator
// Scoreboard bench for seq_generator: the driver queues timed expected bits
// and done pulses, a negedge monitor pops and compares them.
// Revision : 1.0
// ============================================================================
module tb_seq_generator;

    localparam int WIDTH = 16;
    localparam int GAP   = 2;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_len;
    logic             a;
    logic             a_valid;
    logic             busy;
    logic             done;
`ifdef SEQ_GENERATOR_REPEAT_EN
    logic             repeat_en;
`endif

    seq_generator #(.WIDTH(WIDTH), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
`ifdef SEQ_GENERATOR_REPEAT_EN
        .repeat_en  (repeat_en),
`endif
        .a          (a),
        .a_valid    (a_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  hs_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic take(input bit is_done, input logic val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: done=%0b a=%0b at cycle %0d, nothing expected",
                     is_done, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk(is_done ? "done_cycle" : "bit_cycle", cyc, e.cyc);
            chk("event_kind", {31'd0, is_done}, {31'd0, e.is_done});
            if (!is_done) chk("bit_value", {31'd0, val}, {31'd0, e.val});
        end
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event: expected at cycle %0d (done=%0b), now %0d",
                         exp_q[0].cyc, exp_q[0].is_done, cyc);
                void'(exp_q.pop_front());
            end
            if (done) take(1'b1, 1'b0);
            if (a_valid) take(1'b0, a);
            else chk("a_low_when_invalid", {31'd0, a}, 32'd0);
        end
    end

    // Offers a word; queues its expected bits once the handshake is certain.
    task automatic send(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] len, input int L,
                        input bit hold, input logic [WIDTH-1:0] nd, input logic [CNT_W-1:0] nlen);
        int waited = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = len;
        while (!load_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: load_ready 0, expected 1 within 200 cycles");
            load_valid = 1'b0;
            return;
        end
        hs_cyc = cyc + 1;
        for (int k = L - 1; k >= 0; k--)
            exp_q.push_back(ev_t'{hs_cyc + (L - 1 - k), 1'b0, d[k]});
        exp_q.push_back(ev_t'{hs_cyc + L, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        if (hold) begin
            load_data = nd;
            load_len  = nlen;
        end else begin
            load_valid = 1'b0;
            load_data  = WIDTH'($urandom);
            load_len   = CNT_W'($urandom);
        end
    endtask

    // Called 1ns after the handshake edge; load_ready must return after L+GAP edges.
    task automatic wait_ready(input int L);
        int n = 0;
        while (!load_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_return_edges", n, L + GAP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_hs;
        int n;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
`ifdef SEQ_GENERATOR_REPEAT_EN
        repeat_en  = 1'b0;
`endif
        // 1: reset state
        @(negedge clk);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_outputs", {28'd0, a, a_valid, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_load_ready", {31'd0, load_ready}, 32'd1);
        chk("idle_outputs", {28'd0, a, a_valid, busy, done}, 32'd0);

        // 2: 101 pattern
        send(16'h0005, CNT_W'(3), 3, 1'b0, '0, '0);
        chk("busy_after_hs", {31'd0, busy}, 32'd1);
        wait_ready(3);

        // 3: 11-bit word 10110011001
        send(16'h0599, CNT_W'(11), 11, 1'b0, '0, '0);
        wait_ready(11);

        // 4: length 0 means full width; length 1 single bit
        send(16'h8001, CNT_W'(0), 16, 1'b0, '0, '0);
        wait_ready(16);
        send(16'h0001, CNT_W'(1), 1, 1'b0, '0, '0);
        wait_ready(1);

        // 5: async reset mid-word discards the word
        send(16'h02A5, CNT_W'(10), 10, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midword_rst_outputs", {28'd0, a, a_valid, busy, done}, 32'd0);
        chk("midword_rst_ready", {31'd0, load_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, load_ready}, 32'd1);
        send(16'h0005, CNT_W'(3), 3, 1'b0, '0, '0);
        wait_ready(3);

        // 6: load_valid held with new data while busy; second word waits for load_ready
        send(16'h0005, CNT_W'(3), 3, 1'b1, 16'h0599, CNT_W'(11));
        a_hs = hs_cyc;
        send(16'h0599, CNT_W'(11), 11, 1'b0, '0, '0);
        chk("back_to_back_period", hs_cyc - a_hs, 3 + GAP + 1);
        wait_ready(11);

`ifdef SEQ_GENERATOR_REPEAT_EN
        repeat_en = 1'b1;
        send(16'h0005, CNT_W'(3), 3, 1'b0, '0, '0);
        for (int k = 2; k >= 0; k--)
            exp_q.push_back(ev_t'{hs_cyc + 3 + GAP + (2 - k), 1'b0, k[0] ? 1'b0 : 1'b1});
        exp_q.push_back(ev_t'{hs_cyc + 2 * (3 + GAP) - GAP, 1'b1, 1'b0});
        while (cyc < hs_cyc + 3 + GAP + 1) @(posedge clk);
        #1;
        repeat_en = 1'b0;
        n = 0;
        while (!load_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("repeat_ready_cycle", cyc, hs_cyc + 2 * (3 + GAP));
`endif

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
